digit_serial_addsub: RTL and testbench
======================================

# digit_serial_addsub

- Parametrised digit-serial adder/subtractor: one W-bit digit of each operand per cycle, least-significant digit first, N digits per word.
- Adds over its predecessor:
  - Runtime add/subtract mode.
  - Internal word framing by digit counter, with no external first-digit strobe.
  - Valid/ready handshake on input and output.
  - Registered output stage.
  - Final carry and signed-overflow flags.
- Sits between digit-serial operand sources (shift registers, other serial arithmetic) and downstream serial consumers in the datapath.

## Interface
Parameters:
- W, default 4: digit width in bits, ≥1.
- N, default 8: digits per word, ≥2; word width is W·N.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  a, b and sub are presented.
- in_ready  output  1  block accepts a digit this cycle.
- sub  input  1  0 = a+b, 1 = a−b; sampled only on the first digit of a word.
- a  input  W  operand A digit.
- b  input  W  operand B digit.
- out_valid  output  1  s and flags are valid.
- out_ready  input  1  consumer accepts the output digit.
- s  output  W  result digit.
- out_first  output  1  s is digit 0 of a word.
- out_last  output  1  s is digit N−1 of a word.
- c_out  output  1  carry out of the word MSB; valid only with out_last.
- ovf  output  1  two's-complement overflow of the word; valid only with out_last.

## Operation
- Accept condition: in_valid & in_ready.
- in_ready = ~out_valid | out_ready.
  - Combinational from out_valid and out_ready.
  - No combinational path from in_valid.
- Digit counter `idx`, range 0..N−1:
  - Increments on each accept.
  - Wraps from N−1 to 0.
  - idx==0 marks the first digit of a word.
- Mode register `mode_r`:
  - Loaded from sub on an accept with idx==0.
  - Effective mode for the digit at idx==0 is sub itself, not the register.
  - Changes on sub at idx≠0 are ignored.
- Per accepted digit:
  - b' = b ^ {W{mode}}.
  - cin = (idx==0) ? mode : carry_r.
  - {cy, sum} = a + b' + cin, a W+1-bit result.
- carry_r:
  - Loads cy on every accept.
  - Holds when there is no accept.
  - The carry from digit N−1 is never used as cin, because the next word starts at idx==0.
- Output register, loaded on accept:
  - s = sum.
  - out_first = (idx==0).
  - out_last = (idx==N−1).
  - c_out = cy.
  - ovf = cy ^ (carry into bit W−1 of the digit).
- c_out and ovf are zero when out_last=0.
- out_valid:
  - Set on accept.
  - Cleared when out_valid & out_ready and there is no accept in the same cycle.
- Subtract semantics: c_out=1 means no borrow (a ≥ b, unsigned).

## Timing
- Latency: a digit accepted at edge k appears on s with out_valid=1 after edge k, i.e. one cycle.
- Throughput: one digit per cycle while out_ready=1. A full word takes N cycles and there are no bubbles between words.
- Back-pressure:
  - While out_valid=1 and out_ready=0, in_ready=0.
  - s, out_first, out_last, c_out and ovf are held stable.
  - idx, carry_r and mode_r are held.
- Simultaneous output drain and input accept: the register reloads and out_valid stays 1.
- Reset, asynchronous assert:
  - out_valid=0, s=0, out_first=0, out_last=0, c_out=0, ovf=0.
  - idx=0, carry_r=0, mode_r=0.
  - in_ready=1 while in reset-released idle.
- Reset mid-word:
  - The partial word is discarded and no partial flags are emitted.
  - The first accept after release is treated as digit 0.
- in_valid low mid-word: idx and carry_r are held; the word resumes on the next accept.

## Test plan
- Add, W=4 N=2, sub=0, a=0x3C, b=0x15 as digits (C,5),(3,1):
  - s = 1 then 5, i.e. 0x51.
  - out_first on digit 0, out_last on digit 1.
  - c_out=0, ovf=0.
- Subtract, W=4 N=2, sub=1, a=0x15, b=0x3C:
  - Result 0xD9 (digits 9,D).
  - c_out=0 (borrow), ovf=0.
- Overflow, W=4 N=2:
  - Add 0x7F+0x01 → 0x80, ovf=1, c_out=0.
  - Subtract 0x80−0x01 → 0x7F, ovf=1, c_out=1.
- Back-to-back words and mode change:
  - W=4 N=2, words 0x3C+0x15 then 0x15−0x3C with no idle cycle → 0x51 then 0xD9.
  - Toggling sub on digit 1 of either word does not alter the results.
- Back-pressure:
  - Hold out_ready=0 for 3 cycles after digit 0 of 0x3C+0x15.
  - in_ready=0 and s=1 stable throughout.
  - On release, the word completes as 0x51 with correct flags.
- Reset mid-word:
  - Assert reset after digit 0 of 0xFF+0x01.
  - out_valid=0 and all outputs 0 immediately.
  - Next word 0x3C+0x15 yields 0x51, with no stale carry.

Source files
------------

// File: rtl/digit_serial_addsub.sv
// Digit-serial two's-complement adder/subtractor, LSD first, N digits per word.
// Word framing comes from an internal digit counter; output stage is registered.
module digit_serial_addsub #(
    parameter int W = 4,
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] s,
    output logic         out_first,
    output logic         out_last,
    output logic         c_out,
    output logic         ovf
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q;
    logic          mode_q;
    logic          valid_q;
    logic [W-1:0]  s_q;
    logic          first_q, last_q, cout_q, ovf_q;

    logic          acc, is_first, is_last, mode, cin, cy, cmsb;
    logic [W-1:0]  bx;
    logic [W:0]    tot;

    assign in_ready = ~valid_q | out_ready;
    assign acc      = in_valid & in_ready;
    assign is_first = (idx_q == '0);
    assign is_last  = (idx_q == LAST);

    // Digit 0 uses the live sub input; later digits use the latched mode.
    assign mode = is_first ? sub : mode_q;
    assign bx   = b ^ {W{mode}};
    assign cin  = is_first ? mode : carry_q;
    assign tot  = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, cin};
    assign cy   = tot[W];
    assign cmsb = tot[W-1] ^ a[W-1] ^ bx[W-1];

    assign idx_d = is_last ? '0 : idx_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            mode_q  <= 1'b0;
            valid_q <= 1'b0;
            s_q     <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (acc) begin
                idx_q   <= idx_d;
                carry_q <= cy;
                if (is_first)
                    mode_q <= sub;
                s_q     <= tot[W-1:0];
                first_q <= is_first;
                last_q  <= is_last;
                cout_q  <= is_last & cy;
                ovf_q   <= is_last & (cy ^ cmsb);
            end
            if (acc)
                valid_q <= 1'b1;
            else if (out_ready)
                valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign s         = s_q;
    assign out_first = first_q;
    assign out_last  = last_q;
    assign c_out     = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Bench for digit_serial_addsub at W=4, N=2: directed cases plus random words
// compared against a whole-word arithmetic model.
module tb_digit_serial_addsub;

    localparam int W = 4;
    localparam int N = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic         sub;
    logic [W-1:0] a, b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         out_first, out_last, c_out, ovf;

    int pass_cnt = 0;
    int total_cnt = 0;

    digit_serial_addsub #(.W(W), .N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .out_first (out_first),
        .out_last  (out_last),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Whole-word model: {ovf, c_out, result[7:0]}.
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input logic m);
        int ux, uy, t, sx, sy, sr;
        logic [7:0] r;
        ux = int'(x);
        uy = int'(y);
        t  = m ? ux + (255 - uy) + 1 : ux + uy;
        r  = t[7:0];
        sx = (ux > 127) ? ux - 256 : ux;
        sy = (uy > 127) ? uy - 256 : uy;
        sr = m ? sx - sy : sx + sy;
        return {(sr < -128) || (sr > 127), t >= 256, r};
    endfunction

    function automatic logic [8:0] pack_out();
        return {out_valid, out_first, out_last, c_out, ovf, s};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input string tag);
        in_valid = 1'b0;
        step();
        chk(tag, 16'(out_valid), 16'd0);
    endtask

    // Send one word with out_ready=1; optional flip of sub on digit 1 and
    // optional idle gap between digits.
    task automatic send_word(input string tag, input logic [7:0] x, input logic [7:0] y,
                             input logic m, input logic flip, input logic gap);
        logic [9:0] e;
        logic [3:0] ed;
        logic       fl, lf;
        e = model(x, y, m);
        for (int d = 0; d < N; d++) begin
            if (d == 1 && gap)
                idle_cycle({tag, "_gap"});
            in_valid = 1'b1;
            a   = x[d*4 +: 4];
            b   = y[d*4 +: 4];
            sub = (d == 0) ? m : (m ^ flip);
            chk({tag, "_rdy"}, 16'(in_ready), 16'd1);
            step();
            ed = e[d*4 +: 4];
            fl = (d == 0);
            lf = (d == N - 1);
            chk({tag, "_out"}, 16'(pack_out()),
                16'({1'b1, fl, lf, lf & e[8], lf & e[9], ed}));
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sub       = 1'b0;
        a         = '0;
        b         = '0;
        #12;
        chk("reset_out", 16'(pack_out()), 16'd0);
        chk("reset_rdy", 16'(in_ready), 16'd1);
        reset = 1'b0;
        step();

        send_word("add", 8'h3C, 8'h15, 1'b0, 1'b0, 1'b0);
        idle_cycle("drain0");
        send_word("sub", 8'h15, 8'h3C, 1'b1, 1'b0, 1'b0);
        send_word("ovf_add", 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        send_word("ovf_sub", 8'h80, 8'h01, 1'b1, 1'b0, 1'b0);
        send_word("b2b_add", 8'h3C, 8'h15, 1'b0, 1'b1, 1'b0);
        send_word("b2b_sub", 8'h15, 8'h3C, 1'b1, 1'b1, 1'b0);
        idle_cycle("drain1");

        // Back-pressure after digit 0 of 0x3C+0x15.
        in_valid = 1'b1;
        a = 4'hC; b = 4'h5; sub = 1'b0;
        step();
        chk("bp_d0", 16'(pack_out()), 16'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1}));
        a = 4'h3; b = 4'h1; sub = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_rdy", 16'(in_ready), 16'd0);
            step();
            chk("bp_hold", 16'(pack_out()), 16'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1}));
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel_rdy", 16'(in_ready), 16'd1);
        step();
        chk("bp_d1", 16'(pack_out()), 16'({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h5}));
        idle_cycle("drain2");

        // Reset after digit 0 of 0xFF+0x01.
        in_valid = 1'b1;
        a = 4'hF; b = 4'h1; sub = 1'b0;
        step();
        chk("rst_d0", 16'(pack_out()), 16'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0}));
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_mid_out", 16'(pack_out()), 16'd0);
        chk("rst_mid_rdy", 16'(in_ready), 16'd1);
        step();
        reset = 1'b0;
        #1;
        send_word("post_rst", 8'h3C, 8'h15, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            logic [7:0] rx, ry;
            rx = 8'($urandom_range(0, 255));
            ry = 8'($urandom_range(0, 255));
            send_word("rand", rx, ry, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle_cycle("drain_end");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
